// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises and edge-detects external lines, keeps
// pending/mask state, and runs the irq_out request/ack handshake with the core.
module irq_ctrl #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_lines,
    input  logic             irq_en,
    input  logic             irq_ack,
    output logic             irq_out,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    output logic [15:0]      cfg_rdata,
    output logic [3:0]       active_id
);

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_ACTIVE  = 2'd2;
    localparam logic [1:0] ADDR_SOFT    = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DIS
    } state_t;

    state_t state, state_nx;

    logic [N_IRQ-1:0] sync1, sync2, prev;
    logic [N_IRQ-1:0] pending, mask;
    logic [N_IRQ-1:0] rise, elig, win_onehot;
    logic [N_IRQ-1:0] w1c_clr, soft_set, ack_clr;
    logic [3:0]       winner;
    logic             found;
    logic             take_ack;

    assign rise       = sync2 & ~prev;
    assign elig       = pending & mask;
    // Isolates the lowest set bit, i.e. the fixed-priority winner.
    assign win_onehot = elig & (~elig + 1'b1);
    assign take_ack   = (state == REQ) && irq_ack;

    always_comb begin
        winner = 4'hF;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (elig[i] && !found) begin
                winner = 4'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        w1c_clr  = '0;
        soft_set = '0;
        ack_clr  = '0;
        if (cfg_we && cfg_addr == ADDR_PENDING) w1c_clr  = cfg_wdata[N_IRQ-1:0];
        if (cfg_we && cfg_addr == ADDR_SOFT)    soft_set = cfg_wdata[N_IRQ-1:0];
        if (take_ack)                           ack_clr  = win_onehot;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (elig != '0 && irq_en) state_nx = REQ;
            REQ: begin
                if (irq_ack)           state_nx = WAIT_DIS;
                else if (!irq_en)      state_nx = IDLE;
                else if (elig == '0)   state_nx = IDLE;
            end
            WAIT_DIS: if (!irq_en) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            irq_out   <= 1'b0;
            active_id <= 4'hF;
        end else begin
            state   <= state_nx;
            irq_out <= (state_nx == REQ);
            if (take_ack) active_id <= winner;
        end
    end

    // Sets (hardware rise, SOFT) are applied after clears so they win ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            sync1   <= irq_lines;
            sync2   <= sync1;
            prev    <= sync2;
            pending <= (pending & ~w1c_clr & ~ack_clr) | rise | soft_set;
            if (cfg_we && cfg_addr == ADDR_MASK) mask <= cfg_wdata[N_IRQ-1:0];
        end
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            ADDR_MASK:    cfg_rdata[N_IRQ-1:0] = mask;
            ADDR_PENDING: cfg_rdata[N_IRQ-1:0] = pending;
            ADDR_ACTIVE:  cfg_rdata[3:0]       = active_id;
            ADDR_SOFT:    cfg_rdata            = '0;
            default:      cfg_rdata            = '0;
        endcase
    end

endmodule
